serial_nibble_adder_ctrl: RTL and testbench

//  Sequences one 4-bit add stage (a, b, cin -> s, c) across a WIDTH-bit operand.

---
 rtl/serial_nibble_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_nibble_adder_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_adder_ctrl.sv
// serial_nibble_adder_ctrl
// Adds two WIDTH-bit operands one nibble per clock, LSB nibble first,
// reusing a single 4-bit add stage with the carry held in a register.
// Results are published only on completion. A one-cycle done pulse marks a new s/c/v.
module serial_nibble_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic             carry, carry_n;
  logic [WIDTH-1:0] areg, areg_n;
  logic [WIDTH-1:0] breg, breg_n;
  logic [WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0] s_n;
  logic             busy_n, done_n, c_n, v_n;

  logic [3:0]       anib, bnib;
  logic [4:0]       sum5;
  logic [3:0]       low4;
  logic             last;

  // 4-bit add stage on the nibble selected by count
  always_comb begin
    anib = '0;
    bnib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (count == CW'(i)) begin
        anib = areg[4*i +: 4];
        bnib = breg[4*i +: 4];
      end
    end
    sum5 = {1'b0, anib} + {1'b0, bnib} + {4'b0, carry};
    // carry into bit 3 of the nibble; on the MSB nibble this is the carry into bit WIDTH-1
    low4 = {1'b0, anib[2:0]} + {1'b0, bnib[2:0]} + {3'b0, carry};
    last = (count == CW'(NIBBLES - 1));
  end

  // next-state and next-output logic
  always_comb begin
    state_n = state;
    count_n = count;
    carry_n = carry;
    areg_n  = areg;
    breg_n  = breg;
    work_n  = work;
    s_n     = s;
    c_n     = c;
    v_n     = v;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          areg_n  = a;
          breg_n  = b;
          carry_n = cin;
          count_n = '0;
          busy_n  = 1'b1;
          state_n = ADD;
        end
      end
      ADD: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (count == CW'(i)) begin
            work_n[4*i +: 4] = sum5[3:0];
          end
        end
        carry_n = sum5[4];
        count_n = count + 1'b1;
        if (last) begin
          s_n     = work_n;
          c_n     = sum5[4];
          v_n     = low4[3] ^ sum5[4];
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      carry <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      work  <= '0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      carry <= carry_n;
      areg  <= areg_n;
      breg  <= breg_n;
      work  <= work_n;
      s     <= s_n;
      c     <= c_n;
      v     <= v_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Testbench for serial_nibble_adder_ctrl (WIDTH=16).
// The driver predicts accepted operations and queues their results.
// The monitor checks busy/done/s/c/v against that queue on every falling edge.
module tb_serial_nibble_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] a, b;
  logic        busy, done, c, v;
  logic [15:0] s;

  always #5 clk = ~clk;

  serial_nibble_adder_ctrl #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .s    (s),
    .c    (c),
    .v    (v)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          dc;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   la        = -100;
  int   next_free = 0;
  int   checks    = 0;
  int   failures  = 0;
  bit   mon_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // plain-arithmetic reference: 17-bit sum, overflow from operand/result signs
  function automatic exp_t ref_add(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic ci, input int dc);
    exp_t        e;
    logic [16:0] t;
    t    = {1'b0, aa} + {1'b0, bb} + 17'(ci);
    e.s  = t[15:0];
    e.c  = t[16];
    e.v  = (aa[15] == bb[15]) && (t[15] != aa[15]);
    e.dc = dc;
    return e;
  endfunction

  // one clock of stimulus; called 6 time units after a rising edge
  task automatic drive(input bit st, input logic [15:0] aa, input logic [15:0] bb,
                       input bit ci, input bit r, output bit acc);
    start = st;
    a     = aa;
    b     = bb;
    cin   = ci;
    rst   = r;
    acc   = 1'b0;
    if (r) begin
      q.delete();
      la        = -100;
      next_free = 0;
    end else if (st && (cyc + 1 >= next_free)) begin
      acc = 1'b1;
      q.push_back(ref_add(aa, bb, ci, cyc + 1 + 4));
      la        = cyc + 1;
      next_free = cyc + 1 + 5;
    end
    @(posedge clk);
    #6;
  endtask

  task automatic idle(input int n);
    bit dummy;
    for (int i = 0; i < n; i++)
      drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, dummy);
  endtask

  // monitor: compares every output against the scoreboard each falling edge
  logic [15:0] hs = '0;
  logic        hc = 1'b0;
  logic        hv = 1'b0;
  always @(negedge clk) begin
    logic bexp, dexp;
    exp_t e;
    if (mon_en) begin
      if (rst) begin
        hs = '0;
        hc = 1'b0;
        hv = 1'b0;
      end
      bexp = (cyc >= la) && (cyc <= la + 3);
      dexp = (q.size() > 0) && (q[0].dc == cyc);
      chk("busy", 32'(busy), 32'(bexp));
      chk("done", 32'(done), 32'(dexp));
      if (dexp) begin
        e  = q.pop_front();
        hs = e.s;
        hc = e.c;
        hv = e.v;
      end
      chk("sum", 32'(s), 32'(hs));
      chk("carry", 32'(c), 32'(hc));
      chk("ovf", 32'(v), 32'(hv));
    end
  end

  initial begin
    bit          acc;
    logic [15:0] aa, bb;
    logic [3:0]  ln;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #6;
    mon_en = 1'b1;

    // directed operations
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, acc); idle(6);
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, acc); idle(6);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, acc); idle(6);
    drive(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, acc); idle(6);

    // start while busy is ignored
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, acc);
    idle(1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, acc);
    idle(6);

    // reset during the second ADD cycle aborts, then a fresh op
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, acc);
    idle(1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
    idle(2);
    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, acc); idle(6);

    // reset wins over simultaneous start
    drive(1'b1, 16'h5A5A, 16'h1111, 1'b1, 1'b1, acc); idle(6);

    // start held high: back-to-back ops, one result every 5 cycles
    repeat (20) drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, acc);
    idle(6);

    // sweep low nibbles with random upper bits and carry-in
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        aa  = 16'($urandom);
        bb  = 16'($urandom);
        ln  = 4'(i);
        aa[3:0] = ln;
        ln  = 4'(j);
        bb[3:0] = ln;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++)
          drive(1'b1, aa, bb, 1'($urandom), 1'b0, acc);
        chk("accept", 32'(acc), 32'd1);
      end
    end
    idle(6);

    // random traffic with stray starts and occasional resets
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 60) == 0), acc);
    idle(8);

    chk("queue_drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
